led_pattern_drv: RTL and testbench

Output-side counterpart to the debounced key input path. Accepts LED commands over a valid/ready handshake, typically from the key-event logic or a host register block, and drives the board LEDs (LED1..LEDn). Each LED channel independently holds one of four modes: OFF, ON, BLINK, or FLASH (a counted burst). All channels run in the sys_clk_ibufg domain (200 MHz).

---
 rtl/led_pattern_drv.sv | 219 +++++++++++++++++++++
 tb/tb_led_pattern_drv.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_drv.sv
// ---------------------------------------------------------------------------
// led_pattern_drv -- LED command sink and per-channel pattern generator.
//
// Accepts LED commands on a valid/ready handshake and drives N_LED board LEDs.
// Each channel independently runs OFF, ON, BLINK or FLASH (a counted burst of
// HALF_PERIOD-on / HALF_PERIOD-off pulses).
//
// Optional build macro: LED_PATTERN_DIM_EN
//   Adds the dim_level input and a shared 4-bit free-running PWM counter that
//   gates every lit channel (dim_level=15 full, dim_level=0 1/16 duty).
//
// Ports:
//   sys_clk_ibufg  in   system clock (200 MHz)
//   rst_n          in   async active-low reset; release is expected to be
//                       synchronised to sys_clk_ibufg upstream
//   cmd_valid      in   command strobe
//   cmd_ready      out  command accept (0 in reset, 1 from first cycle after)
//   cmd_led        in   target channel; indices >= N_LED are accepted and dropped
//   cmd_mode       in   0=OFF 1=ON 2=BLINK 3=FLASH
//   cmd_count      in   FLASH pulse count (0 = immediate done, LED off)
//   dim_level      in   brightness 0..15 (LED_PATTERN_DIM_EN only)
//   busy           out  per-channel: FLASH burst in progress
//   done           out  per-channel: 1-cycle pulse when a burst completes
//   led_out        out  LED pins, lit level set by ACTIVE_LOW
// ---------------------------------------------------------------------------

// Per-channel mode/phase/pulse state. lit_nxt is the next-cycle lit level so
// the top can register the pin on the same edge the state updates.
module led_pattern_chan #(
    parameter int HALF_PERIOD = 50_000_000
) (
    input  logic       sys_clk_ibufg,
    input  logic       rst_n,
    input  logic       cmd_hit,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic       lit_nxt,
    output logic       busy,
    output logic       done
);
    localparam int            PW         = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_FLASH = 2'd3;

    logic [1:0]    mode_q, mode_d;
    logic          lit_q, lit_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    remaining_q, remaining_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          phase_end;

    assign phase_end = (phase_q == PHASE_LAST);

    always_comb begin
        mode_d      = mode_q;
        lit_d       = lit_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (cmd_hit) begin
            // A new command always wins, even over a burst finishing this cycle;
            // an aborted burst never reports done.
            phase_d     = '0;
            busy_d      = 1'b0;
            remaining_d = '0;
            case (cmd_mode)
                MODE_OFF: begin
                    mode_d = MODE_OFF;
                    lit_d  = 1'b0;
                end
                MODE_ON: begin
                    mode_d = MODE_ON;
                    lit_d  = 1'b1;
                end
                MODE_BLINK: begin
                    mode_d = MODE_BLINK;
                    lit_d  = 1'b1;
                end
                default: begin
                    if (cmd_count == 4'd0) begin
                        mode_d = MODE_OFF;
                        lit_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        mode_d      = MODE_FLASH;
                        lit_d       = 1'b1;
                        busy_d      = 1'b1;
                        remaining_d = cmd_count;
                    end
                end
            endcase
        end else if (mode_q == MODE_BLINK || mode_q == MODE_FLASH) begin
            phase_d = phase_end ? '0 : phase_q + 1'b1;
            if (phase_end) begin
                if (mode_q == MODE_BLINK) begin
                    lit_d = ~lit_q;
                end else if (lit_q) begin
                    lit_d = 1'b0;
                end else begin
                    // End of an OFF half closes one pulse.
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_d == 4'd0) begin
                        mode_d = MODE_OFF;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        lit_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk_ibufg or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            lit_q       <= 1'b0;
            phase_q     <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            lit_q       <= lit_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign lit_nxt = lit_d;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

module led_pattern_drv #(
    parameter int N_LED       = 2,
    parameter int HALF_PERIOD = 50_000_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             sys_clk_ibufg,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_led,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_count,
`ifdef LED_PATTERN_DIM_EN
    input  logic [3:0]       dim_level,
`endif
    output logic [N_LED-1:0] busy,
    output logic [N_LED-1:0] done,
    output logic [N_LED-1:0] led_out
);
    localparam logic [N_LED-1:0] DARK = {N_LED{1'(ACTIVE_LOW)}};

    logic             cmd_ready_q, cmd_ready_d;
    logic             cmd_fire;
    logic [N_LED-1:0] lit_nxt;
    logic [N_LED-1:0] lit_final;
    logic [N_LED-1:0] led_out_q, led_out_d;

    assign cmd_fire = cmd_valid && cmd_ready_q;

    for (genvar i = 0; i < N_LED; i++) begin : g_chan
        led_pattern_chan #(.HALF_PERIOD(HALF_PERIOD)) u_chan (
            .sys_clk_ibufg (sys_clk_ibufg),
            .rst_n         (rst_n),
            .cmd_hit       (cmd_fire && (cmd_led == 3'(i))),
            .cmd_mode      (cmd_mode),
            .cmd_count     (cmd_count),
            .lit_nxt       (lit_nxt[i]),
            .busy          (busy[i]),
            .done          (done[i])
        );
    end

`ifdef LED_PATTERN_DIM_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;

    // Gate with the next PWM count so the pin and counter move on the same edge.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        lit_final = lit_nxt & {N_LED{(pwm_cnt_d <= dim_level)}};
    end

    always_ff @(posedge sys_clk_ibufg or negedge rst_n) begin
        if (!rst_n) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_d;
    end
`else
    always_comb lit_final = lit_nxt;
`endif

    always_comb begin
        cmd_ready_d = 1'b1;
        led_out_d   = lit_final ^ DARK;
    end

    always_ff @(posedge sys_clk_ibufg or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            led_out_q   <= DARK;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            led_out_q   <= led_out_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign led_out   = led_out_q;
endmodule

// File: tb/tb_led_pattern_drv.sv
// Directed bench for led_pattern_drv, N_LED=2, HALF_PERIOD=10, ACTIVE_LOW=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// "Cycle k after accept" is the k-th falling edge after the accepting rising edge.
module tb_led_pattern_drv;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_led = '0;
    logic [1:0] cmd_mode = '0;
    logic [3:0] cmd_count = '0;
`ifdef LED_PATTERN_DIM_EN
    logic [3:0] dim_level = 4'd15;
`endif
    logic [1:0] busy, done, led_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_drv #(.N_LED(2), .HALF_PERIOD(10), .ACTIVE_LOW(1)) dut (
        .sys_clk_ibufg (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_led       (cmd_led),
        .cmd_mode      (cmd_mode),
        .cmd_count     (cmd_count),
`ifdef LED_PATTERN_DIM_EN
        .dim_level     (dim_level),
`endif
        .busy          (busy),
        .done          (done),
        .led_out       (led_out)
    );

    // Presents one command for one cycle; returns at cycle 1 after accept.
    task automatic send_cmd(input logic [2:0] led, input logic [1:0] mode, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_led   = led;
        cmd_mode  = mode;
        cmd_count = cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (led_out !== 2'b11) begin n_fail++; $display("FAIL reset_led: got %b want 11", led_out); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b want 1", cmd_ready); end
        // Reset mid-BLINK, asserted between edges.
        send_cmd(3'd1, 2'd2, 4'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (led_out !== 2'b11) begin n_fail++; $display("FAIL async_reset_led: got %b want 11", led_out); end
        n_checks++; if (busy !== 2'b00 || done !== 2'b00) begin n_fail++; $display("FAIL async_reset_busy_done: got %b/%b want 00/00", busy, done); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b want 0", cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release: got %b want 0", cmd_ready); end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1 || led_out !== 2'b11) begin n_fail++; $display("FAIL first_cycle_after_release: ready=%b led=%b want 1/11", cmd_ready, led_out); end
    endtask

    task automatic test_on_off;
        send_cmd(3'd0, 2'd1, 4'd0);
        n_checks++; if (led_out !== 2'b10) begin n_fail++; $display("FAIL on_led0: got %b want 10", led_out); end
        repeat (3) @(negedge clk);
        n_checks++; if (led_out !== 2'b10) begin n_fail++; $display("FAIL on_hold: got %b want 10", led_out); end
        send_cmd(3'd0, 2'd0, 4'd0);
        n_checks++; if (led_out !== 2'b11) begin n_fail++; $display("FAIL off_led0: got %b want 11", led_out); end
    endtask

    task automatic test_blink;
        logic exp_pin;
        send_cmd(3'd1, 2'd2, 4'd0);
        for (int k = 1; k <= 40; k++) begin
            exp_pin = (((k - 1) / 10) % 2 == 0) ? 1'b0 : 1'b1;
            n_checks++;
            if (led_out !== {exp_pin, 1'b1}) begin
                n_fail++; $display("FAIL blink_k%0d: got %b want %b", k, led_out, {exp_pin, 1'b1});
            end
            @(negedge clk);
        end
        send_cmd(3'd1, 2'd0, 4'd0);
        n_checks++; if (led_out !== 2'b11) begin n_fail++; $display("FAIL blink_off: got %b want 11", led_out); end
    endtask

    task automatic test_flash;
        logic exp_pin, exp_busy, exp_done;
        send_cmd(3'd0, 2'd3, 4'd3);
        for (int k = 1; k <= 65; k++) begin
            exp_pin  = (k <= 60 && ((k - 1) / 10) % 2 == 0) ? 1'b0 : 1'b1;
            exp_busy = (k <= 60);
            exp_done = (k == 61);
            n_checks++;
            if (led_out !== {1'b1, exp_pin}) begin n_fail++; $display("FAIL flash_led_k%0d: got %b want %b", k, led_out, {1'b1, exp_pin}); end
            n_checks++;
            if (busy !== {1'b0, exp_busy}) begin n_fail++; $display("FAIL flash_busy_k%0d: got %b want %b", k, busy, {1'b0, exp_busy}); end
            n_checks++;
            if (done !== {1'b0, exp_done}) begin n_fail++; $display("FAIL flash_done_k%0d: got %b want %b", k, done, {1'b0, exp_done}); end
            @(negedge clk);
        end
    endtask

    task automatic test_abort;
        send_cmd(3'd0, 2'd3, 4'd5);
        repeat (23) @(negedge clk);
        n_checks++; if (busy !== 2'b01) begin n_fail++; $display("FAIL abort_busy_before: got %b want 01", busy); end
        send_cmd(3'd0, 2'd1, 4'd0);  // accepted at cycle 25 of the burst
        for (int k = 0; k < 30; k++) begin
            n_checks++;
            if (busy !== 2'b00 || done !== 2'b00 || led_out !== 2'b10) begin
                n_fail++; $display("FAIL abort_k%0d: busy=%b done=%b led=%b want 00/00/10", k, busy, done, led_out);
            end
            @(negedge clk);
        end
        send_cmd(3'd0, 2'd0, 4'd0);
        // Out-of-range channel: accepted, no effect.
        send_cmd(3'd5, 2'd1, 4'd0);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bad_led_ready: got %b want 1", cmd_ready); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (led_out !== 2'b11 || busy !== 2'b00 || done !== 2'b00) begin
                n_fail++; $display("FAIL bad_led_k%0d: led=%b busy=%b done=%b want 11/00/00", k, led_out, busy, done);
            end
            @(negedge clk);
        end
        // FLASH with zero count: immediate done, LED dark.
        send_cmd(3'd0, 2'd3, 4'd0);
        n_checks++;
        if (done !== 2'b01 || busy !== 2'b00 || led_out !== 2'b11) begin
            n_fail++; $display("FAIL flash0: done=%b busy=%b led=%b want 01/00/11", done, busy, led_out);
        end
        @(negedge clk);
        n_checks++; if (done !== 2'b00) begin n_fail++; $display("FAIL flash0_pulse_width: got %b want 00", done); end
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_led = 3'd0; cmd_mode = 2'd1; cmd_count = 4'd0;
        @(negedge clk);
        n_checks++; if (led_out !== 2'b10) begin n_fail++; $display("FAIL b2b_first: got %b want 10", led_out); end
        cmd_led = 3'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (led_out !== 2'b00) begin n_fail++; $display("FAIL b2b_second: got %b want 00", led_out); end
        send_cmd(3'd0, 2'd0, 4'd0);
        send_cmd(3'd1, 2'd0, 4'd0);
        n_checks++; if (led_out !== 2'b11) begin n_fail++; $display("FAIL b2b_off: got %b want 11", led_out); end
    endtask

`ifdef LED_PATTERN_DIM_EN
    task automatic test_dim;
        int lows;
        dim_level = 4'd3;
        send_cmd(3'd0, 2'd1, 4'd0);
        lows = 0;
        for (int k = 0; k < 32; k++) begin
            if (led_out[0] === 1'b0) lows++;
            @(negedge clk);
        end
        n_checks++; if (lows !== 8) begin n_fail++; $display("FAIL dim3_duty: got %0d low of 32 want 8", lows); end
        dim_level = 4'd15;
        @(negedge clk);
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            if (led_out[0] === 1'b0) lows++;
            @(negedge clk);
        end
        n_checks++; if (lows !== 16) begin n_fail++; $display("FAIL dim15_duty: got %0d low of 16 want 16", lows); end
        send_cmd(3'd0, 2'd0, 4'd0);
    endtask
`endif

    initial begin
        test_reset;
        test_on_off;
        test_blink;
        test_flash;
        test_abort;
        test_back_to_back;
`ifdef LED_PATTERN_DIM_EN
        test_dim;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
